// File: rtl/corevx_cache_arbiter_pkg.sv
// Shared corevx cache-port encodings, payload struct and arbiter owner encoding.
package corevx_cache_arbiter_pkg;

    localparam int unsigned CMD_W        = 4;
    localparam int unsigned RESP_W       = 4;
    localparam int unsigned ADDR_W       = 32;
    localparam int unsigned DATA_W       = 32;
    localparam int unsigned LOAD_TYPE_W  = 3;
    localparam int unsigned STORE_TYPE_W = 2;

    typedef logic [CMD_W-1:0]        cache_cmd_t;
    typedef logic [RESP_W-1:0]       cache_resp_t;
    typedef logic [ADDR_W-1:0]       cache_addr_t;
    typedef logic [DATA_W-1:0]       cache_data_t;
    typedef logic [LOAD_TYPE_W-1:0]  load_type_t;
    typedef logic [STORE_TYPE_W-1:0] store_type_t;

    localparam cache_cmd_t CACHE_CMD_NONE      = 4'd0;
    localparam cache_cmd_t CACHE_CMD_LOAD      = 4'd1;
    localparam cache_cmd_t CACHE_CMD_STORE     = 4'd2;
    localparam cache_cmd_t CACHE_CMD_EXECUTE   = 4'd3;
    localparam cache_cmd_t CACHE_CMD_FLUSH_ALL = 4'd4;

    localparam cache_resp_t CACHE_RESPONSE_IDLE         = 4'd0;
    localparam cache_resp_t CACHE_RESPONSE_WAIT         = 4'd1;
    localparam cache_resp_t CACHE_RESPONSE_DONE         = 4'd2;
    localparam cache_resp_t CACHE_RESPONSE_PAGEFAULT    = 4'd3;
    localparam cache_resp_t CACHE_RESPONSE_ACCESS_FAULT = 4'd4;
    localparam cache_resp_t CACHE_RESPONSE_MISALIGNED   = 4'd5;

    localparam load_type_t LOAD_B  = 3'd0;
    localparam load_type_t LOAD_H  = 3'd1;
    localparam load_type_t LOAD_W  = 3'd2;
    localparam load_type_t LOAD_BU = 3'd3;
    localparam load_type_t LOAD_HU = 3'd4;

    localparam store_type_t STORE_B = 2'd0;
    localparam store_type_t STORE_H = 2'd1;
    localparam store_type_t STORE_W = 2'd2;

    typedef enum logic [1:0] {
        OWNER_NONE  = 2'd0,
        OWNER_FETCH = 2'd1,
        OWNER_EXEC  = 2'd2
    } owner_e;

    typedef struct packed {
        cache_cmd_t  cmd;
        cache_addr_t address;
        load_type_t  load_type;
        store_type_t store_type;
        cache_data_t store_data;
    } cache_req_t;

    // DONE and every error code end a transaction; WAIT and IDLE do not.
    function automatic logic is_terminal(input cache_resp_t resp);
        return (resp != CACHE_RESPONSE_WAIT) && (resp != CACHE_RESPONSE_IDLE);
    endfunction

endpackage

// File: rtl/corevx_cache_arbiter_if.sv
// Bundle of the fetch, execute and cache-side signals around the cache-port arbiter.
interface corevx_cache_arbiter_if
    import corevx_cache_arbiter_pkg::*;
;
    cache_cmd_t  f_cmd;
    cache_addr_t f_address;
    cache_resp_t f_response;
    logic        f_reset_done;
    cache_data_t f_load_data;

    cache_cmd_t  e_cmd;
    cache_addr_t e_address;
    load_type_t  e_load_type;
    store_type_t e_store_type;
    cache_data_t e_store_data;
    cache_resp_t e_response;
    logic        e_reset_done;
    cache_data_t e_load_data;

    cache_cmd_t  c_cmd;
    cache_addr_t c_address;
    load_type_t  c_load_type;
    store_type_t c_store_type;
    cache_data_t c_store_data;
    cache_resp_t c_response;
    logic        c_reset_done;
    cache_data_t c_load_data;

    // Requesters and cache: everything the arbiter consumes is driven from here.
    modport master (
        output f_cmd, f_address,
        input  f_response, f_reset_done, f_load_data,
        output e_cmd, e_address, e_load_type, e_store_type, e_store_data,
        input  e_response, e_reset_done, e_load_data,
        input  c_cmd, c_address, c_load_type, c_store_type, c_store_data,
        output c_response, c_reset_done, c_load_data
    );

    // Arbiter view.
    modport slave (
        input  f_cmd, f_address,
        output f_response, f_reset_done, f_load_data,
        input  e_cmd, e_address, e_load_type, e_store_type, e_store_data,
        output e_response, e_reset_done, e_load_data,
        output c_cmd, c_address, c_load_type, c_store_type, c_store_data,
        input  c_response, c_reset_done, c_load_data
    );

endinterface

// File: rtl/corevx_cache_arbiter.sv
// Shares one corevx cache port between fetch and execute: execute has priority,
// the port is locked to its owner until a terminal response, fetch cannot starve.
module corevx_cache_arbiter
    import corevx_cache_arbiter_pkg::*;
#(
    parameter int unsigned FETCH_STARVE_LIMIT = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    corevx_cache_arbiter_if.slave  bus
);

    localparam int unsigned STARVE_W = $clog2(FETCH_STARVE_LIMIT + 1);

    owner_e              owner_q;
    logic [STARVE_W-1:0] starve_q;

    logic       f_req;
    logic       e_req;
    logic       terminal;
    logic       port_ready;
    logic       arb_open;
    logic       starved;
    owner_e     winner;
    owner_e     sel;
    cache_req_t f_payload;
    cache_req_t e_payload;
    cache_req_t c_payload;

    // Arbitration decision for the current cycle.
    always_comb begin
        f_req      = (bus.f_cmd != CACHE_CMD_NONE);
        e_req      = (bus.e_cmd != CACHE_CMD_NONE);
        terminal   = is_terminal(bus.c_response);
        port_ready = rst_n && bus.c_reset_done;
        arb_open   = port_ready && ((owner_q == OWNER_NONE) || terminal);
        starved    = (starve_q == STARVE_W'(FETCH_STARVE_LIMIT));

        winner = OWNER_NONE;
        if (f_req && (!e_req || starved)) begin
            winner = OWNER_FETCH;
        end else if (e_req) begin
            winner = OWNER_EXEC;
        end

        sel = OWNER_NONE;
        if (port_ready) begin
            sel = arb_open ? winner : owner_q;
        end
    end

    // Request mux; fetch never carries load/store qualifiers.
    always_comb begin
        f_payload = '{cmd: bus.f_cmd, address: bus.f_address,
                      load_type: '0, store_type: '0, store_data: '0};
        e_payload = '{cmd: bus.e_cmd, address: bus.e_address,
                      load_type: bus.e_load_type, store_type: bus.e_store_type,
                      store_data: bus.e_store_data};
        c_payload = '0;
        case (sel)
            OWNER_FETCH: c_payload = f_payload;
            OWNER_EXEC:  c_payload = e_payload;
            default:     c_payload = '0;
        endcase
    end

    assign bus.c_cmd        = c_payload.cmd;
    assign bus.c_address    = c_payload.address;
    assign bus.c_load_type  = c_payload.load_type;
    assign bus.c_store_type = c_payload.store_type;
    assign bus.c_store_data = c_payload.store_data;

    // The owner, or the fresh winner of an idle port, sees the cache response.
    always_comb begin
        bus.f_response = f_req ? CACHE_RESPONSE_WAIT : CACHE_RESPONSE_IDLE;
        bus.e_response = e_req ? CACHE_RESPONSE_WAIT : CACHE_RESPONSE_IDLE;
        if (!port_ready) begin
            bus.f_response = bus.c_response;
            bus.e_response = bus.c_response;
        end else begin
            if ((owner_q == OWNER_FETCH) ||
                ((owner_q == OWNER_NONE) && (winner == OWNER_FETCH))) begin
                bus.f_response = bus.c_response;
            end
            if ((owner_q == OWNER_EXEC) ||
                ((owner_q == OWNER_NONE) && (winner == OWNER_EXEC))) begin
                bus.e_response = bus.c_response;
            end
        end
    end

    assign bus.f_reset_done = bus.c_reset_done;
    assign bus.e_reset_done = bus.c_reset_done;
    assign bus.f_load_data  = bus.c_load_data;
    assign bus.e_load_data  = bus.c_load_data;

    // Port lock and fetch starvation counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q  <= OWNER_NONE;
            starve_q <= '0;
        end else if (arb_open) begin
            owner_q <= winner;
            if (winner == OWNER_FETCH) begin
                starve_q <= '0;
            end else if ((winner == OWNER_EXEC) && f_req && !starved) begin
                starve_q <= starve_q + STARVE_W'(1);
            end
        end
    end

    // An owner must keep its command up while the cache is still working on it.
    owner_holds_cmd: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.c_reset_done && (bus.c_response == CACHE_RESPONSE_WAIT) &&
         (owner_q != OWNER_NONE))
        |-> ((owner_q == OWNER_FETCH) ? f_req : e_req));

endmodule

// File: tb/tb_corevx_cache_arbiter.sv
// Directed bench for corevx_cache_arbiter: reset, locking, priority, starvation, errors.
module tb_corevx_cache_arbiter;
    import corevx_cache_arbiter_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    corevx_cache_arbiter_if bus ();

    corevx_cache_arbiter #(.FETCH_STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.c_reset_done = 1'b0; bus.c_response = CACHE_RESPONSE_IDLE; bus.c_load_data = '0;
        bus.f_cmd = CACHE_CMD_EXECUTE; bus.f_address = 32'h0;
        bus.e_cmd = CACHE_CMD_LOAD; bus.e_address = 32'h0; bus.e_load_type = LOAD_B;
        bus.e_store_type = STORE_B; bus.e_store_data = '0;
        #1;
        n_checks++; if (bus.c_cmd !== CACHE_CMD_NONE) $display("FAIL rst_c_cmd got %0h exp %0h", bus.c_cmd, CACHE_CMD_NONE); else n_pass++;
        n_checks++; if (dut.owner_q !== OWNER_NONE) $display("FAIL rst_owner got %0d exp %0d", dut.owner_q, OWNER_NONE); else n_pass++;
        n_checks++; if (bus.f_response !== CACHE_RESPONSE_IDLE) $display("FAIL rst_f_resp got %0h exp %0h", bus.f_response, CACHE_RESPONSE_IDLE); else n_pass++;
        tick; tick;
        rst_n = 1'b1; bus.f_cmd = CACHE_CMD_NONE; bus.c_response = CACHE_RESPONSE_WAIT;
        #1;
        n_checks++; if (bus.c_cmd !== CACHE_CMD_NONE) $display("FAIL nrd_c_cmd got %0h exp %0h", bus.c_cmd, CACHE_CMD_NONE); else n_pass++;
        n_checks++; if (bus.f_response !== CACHE_RESPONSE_WAIT) $display("FAIL nrd_f_resp got %0h exp %0h", bus.f_response, CACHE_RESPONSE_WAIT); else n_pass++;
        n_checks++; if (bus.e_reset_done !== 1'b0) $display("FAIL nrd_e_reset_done got %0b exp 0", bus.e_reset_done); else n_pass++;
        tick; tick;
        n_checks++; if (dut.owner_q !== OWNER_NONE) $display("FAIL nrd_owner got %0d exp %0d", dut.owner_q, OWNER_NONE); else n_pass++;
        bus.c_reset_done = 1'b1; bus.e_cmd = CACHE_CMD_NONE; bus.c_response = CACHE_RESPONSE_IDLE;
        #1;
        n_checks++; if (bus.f_response !== CACHE_RESPONSE_IDLE) $display("FAIL rd_f_resp got %0h exp %0h", bus.f_response, CACHE_RESPONSE_IDLE); else n_pass++;
        n_checks++; if (bus.e_response !== CACHE_RESPONSE_IDLE) $display("FAIL rd_e_resp got %0h exp %0h", bus.e_response, CACHE_RESPONSE_IDLE); else n_pass++;
        n_checks++; if (bus.f_reset_done !== 1'b1) $display("FAIL rd_f_reset_done got %0b exp 1", bus.f_reset_done); else n_pass++;
        tick;
    endtask

    task automatic test_fetch_only;
        bus.f_cmd = CACHE_CMD_EXECUTE; bus.f_address = 32'h2000; bus.c_response = CACHE_RESPONSE_IDLE;
        #1;
        n_checks++; if (bus.c_cmd !== CACHE_CMD_EXECUTE) $display("FAIL fo_c_cmd got %0h exp %0h", bus.c_cmd, CACHE_CMD_EXECUTE); else n_pass++;
        n_checks++; if (bus.c_address !== 32'h2000) $display("FAIL fo_c_addr got %h exp %h", bus.c_address, 32'h2000); else n_pass++;
        n_checks++; if (bus.f_response !== CACHE_RESPONSE_IDLE) $display("FAIL fo_f_resp0 got %0h exp %0h", bus.f_response, CACHE_RESPONSE_IDLE); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            tick;
            bus.c_response = CACHE_RESPONSE_WAIT;
            #1;
            n_checks++; if (bus.f_response !== CACHE_RESPONSE_WAIT) $display("FAIL fo_f_wait%0d got %0h exp %0h", i, bus.f_response, CACHE_RESPONSE_WAIT); else n_pass++;
            n_checks++; if (bus.c_cmd !== CACHE_CMD_EXECUTE) $display("FAIL fo_c_cmd_wait%0d got %0h exp %0h", i, bus.c_cmd, CACHE_CMD_EXECUTE); else n_pass++;
        end
        tick;
        bus.c_response = CACHE_RESPONSE_DONE; bus.c_load_data = 32'h0000_0013; bus.f_cmd = CACHE_CMD_NONE;
        #1;
        n_checks++; if (bus.f_response !== CACHE_RESPONSE_DONE) $display("FAIL fo_f_done got %0h exp %0h", bus.f_response, CACHE_RESPONSE_DONE); else n_pass++;
        n_checks++; if (bus.f_load_data !== 32'h13) $display("FAIL fo_f_data got %h exp %h", bus.f_load_data, 32'h13); else n_pass++;
        n_checks++; if (bus.e_response !== CACHE_RESPONSE_IDLE) $display("FAIL fo_e_resp got %0h exp %0h", bus.e_response, CACHE_RESPONSE_IDLE); else n_pass++;
        n_checks++; if (bus.c_cmd !== CACHE_CMD_NONE) $display("FAIL fo_c_cmd_done got %0h exp %0h", bus.c_cmd, CACHE_CMD_NONE); else n_pass++;
        tick;
        bus.c_response = CACHE_RESPONSE_IDLE;
        #1;
        n_checks++; if (dut.owner_q !== OWNER_NONE) $display("FAIL fo_owner got %0d exp %0d", dut.owner_q, OWNER_NONE); else n_pass++;
    endtask

    task automatic test_exec_priority;
        bus.f_cmd = CACHE_CMD_EXECUTE; bus.f_address = 32'h3000;
        bus.e_cmd = CACHE_CMD_LOAD; bus.e_address = 32'h100; bus.e_load_type = LOAD_W;
        bus.c_response = CACHE_RESPONSE_IDLE;
        #1;
        n_checks++; if (bus.c_cmd !== CACHE_CMD_LOAD) $display("FAIL pr_c_cmd got %0h exp %0h", bus.c_cmd, CACHE_CMD_LOAD); else n_pass++;
        n_checks++; if (bus.c_load_type !== LOAD_W) $display("FAIL pr_c_ltype got %0h exp %0h", bus.c_load_type, LOAD_W); else n_pass++;
        n_checks++; if (bus.e_response !== CACHE_RESPONSE_IDLE) $display("FAIL pr_e_resp got %0h exp %0h", bus.e_response, CACHE_RESPONSE_IDLE); else n_pass++;
        n_checks++; if (bus.f_response !== CACHE_RESPONSE_WAIT) $display("FAIL pr_f_resp got %0h exp %0h", bus.f_response, CACHE_RESPONSE_WAIT); else n_pass++;
        for (int i = 0; i < 2; i++) begin
            tick;
            bus.c_response = CACHE_RESPONSE_WAIT;
            #1;
            n_checks++; if (bus.f_response !== CACHE_RESPONSE_WAIT) $display("FAIL pr_f_wait%0d got %0h exp %0h", i, bus.f_response, CACHE_RESPONSE_WAIT); else n_pass++;
            n_checks++; if (bus.c_address !== 32'h100) $display("FAIL pr_c_addr%0d got %h exp %h", i, bus.c_address, 32'h100); else n_pass++;
        end
        tick;
        bus.c_response = CACHE_RESPONSE_DONE; bus.c_load_data = 32'hDEAD_BEEF; bus.e_cmd = CACHE_CMD_NONE;
        #1;
        n_checks++; if (bus.e_response !== CACHE_RESPONSE_DONE) $display("FAIL pr_e_done got %0h exp %0h", bus.e_response, CACHE_RESPONSE_DONE); else n_pass++;
        n_checks++; if (bus.e_load_data !== 32'hDEAD_BEEF) $display("FAIL pr_e_data got %h exp %h", bus.e_load_data, 32'hDEAD_BEEF); else n_pass++;
        n_checks++; if (bus.c_cmd !== CACHE_CMD_EXECUTE) $display("FAIL pr_handoff_cmd got %0h exp %0h", bus.c_cmd, CACHE_CMD_EXECUTE); else n_pass++;
        n_checks++; if (bus.c_address !== 32'h3000) $display("FAIL pr_handoff_addr got %h exp %h", bus.c_address, 32'h3000); else n_pass++;
        n_checks++; if (bus.c_load_type !== 3'd0) $display("FAIL pr_handoff_ltype got %0h exp 0", bus.c_load_type); else n_pass++;
        n_checks++; if (bus.f_response !== CACHE_RESPONSE_WAIT) $display("FAIL pr_handoff_f_resp got %0h exp %0h", bus.f_response, CACHE_RESPONSE_WAIT); else n_pass++;
        tick;
        bus.c_response = CACHE_RESPONSE_WAIT;
        #1;
        n_checks++; if (bus.f_response !== CACHE_RESPONSE_WAIT) $display("FAIL pr_f_own_wait got %0h exp %0h", bus.f_response, CACHE_RESPONSE_WAIT); else n_pass++;
        tick;
        bus.c_response = CACHE_RESPONSE_DONE; bus.f_cmd = CACHE_CMD_NONE;
        #1;
        n_checks++; if (bus.f_response !== CACHE_RESPONSE_DONE) $display("FAIL pr_f_done got %0h exp %0h", bus.f_response, CACHE_RESPONSE_DONE); else n_pass++;
        tick;
        bus.c_response = CACHE_RESPONSE_IDLE;
    endtask

    task automatic test_starvation;
        bus.f_cmd = CACHE_CMD_EXECUTE; bus.f_address = 32'h4000;
        bus.e_cmd = CACHE_CMD_LOAD; bus.e_address = 32'h200; bus.e_load_type = LOAD_W;
        bus.c_response = CACHE_RESPONSE_IDLE;
        #1;
        n_checks++; if (bus.c_cmd !== CACHE_CMD_LOAD) $display("FAIL st_arb1_cmd got %0h exp %0h", bus.c_cmd, CACHE_CMD_LOAD); else n_pass++;
        for (int k = 2; k <= 4; k++) begin
            tick;
            bus.c_response = CACHE_RESPONSE_WAIT;
            #1;
            tick;
            bus.c_response = CACHE_RESPONSE_DONE; bus.e_address = 32'h200 + 32'(k * 4);
            #1;
            n_checks++; if (bus.c_cmd !== CACHE_CMD_LOAD) $display("FAIL st_arb%0d_cmd got %0h exp %0h", k, bus.c_cmd, CACHE_CMD_LOAD); else n_pass++;
            n_checks++; if (bus.f_response !== CACHE_RESPONSE_WAIT) $display("FAIL st_arb%0d_f_resp got %0h exp %0h", k, bus.f_response, CACHE_RESPONSE_WAIT); else n_pass++;
        end
        tick;
        bus.c_response = CACHE_RESPONSE_WAIT;
        #1;
        tick;
        bus.c_response = CACHE_RESPONSE_DONE;
        #1;
        n_checks++; if (bus.c_cmd !== CACHE_CMD_EXECUTE) $display("FAIL st_arb5_cmd got %0h exp %0h", bus.c_cmd, CACHE_CMD_EXECUTE); else n_pass++;
        n_checks++; if (bus.c_address !== 32'h4000) $display("FAIL st_arb5_addr got %h exp %h", bus.c_address, 32'h4000); else n_pass++;
        n_checks++; if (bus.e_response !== CACHE_RESPONSE_DONE) $display("FAIL st_arb5_e_resp got %0h exp %0h", bus.e_response, CACHE_RESPONSE_DONE); else n_pass++;
        tick;
        bus.c_response = CACHE_RESPONSE_WAIT;
        #1;
        n_checks++; if (dut.starve_q !== 3'd0) $display("FAIL st_starve_clear got %0d exp 0", dut.starve_q); else n_pass++;
        n_checks++; if (bus.e_response !== CACHE_RESPONSE_WAIT) $display("FAIL st_e_blocked got %0h exp %0h", bus.e_response, CACHE_RESPONSE_WAIT); else n_pass++;
        tick;
        bus.c_response = CACHE_RESPONSE_DONE; bus.f_cmd = CACHE_CMD_NONE;
        #1;
        n_checks++; if (bus.c_cmd !== CACHE_CMD_LOAD) $display("FAIL st_exec_back_cmd got %0h exp %0h", bus.c_cmd, CACHE_CMD_LOAD); else n_pass++;
        tick;
        bus.c_response = CACHE_RESPONSE_WAIT;
        #1;
        tick;
        bus.c_response = CACHE_RESPONSE_DONE; bus.e_cmd = CACHE_CMD_NONE;
        #1;
        tick;
        bus.c_response = CACHE_RESPONSE_IDLE;
    endtask

    task automatic test_error_release;
        bus.f_cmd = CACHE_CMD_EXECUTE; bus.f_address = 32'h5000;
        bus.e_cmd = CACHE_CMD_STORE; bus.e_address = 32'h8000; bus.e_load_type = LOAD_B;
        bus.e_store_type = STORE_W; bus.e_store_data = 32'hCAFE_F00D;
        bus.c_response = CACHE_RESPONSE_IDLE;
        #1;
        n_checks++; if (bus.c_cmd !== CACHE_CMD_STORE) $display("FAIL pf_c_cmd got %0h exp %0h", bus.c_cmd, CACHE_CMD_STORE); else n_pass++;
        n_checks++; if (bus.c_store_type !== STORE_W) $display("FAIL pf_c_stype got %0h exp %0h", bus.c_store_type, STORE_W); else n_pass++;
        n_checks++; if (bus.c_store_data !== 32'hCAFE_F00D) $display("FAIL pf_c_sdata got %h exp %h", bus.c_store_data, 32'hCAFE_F00D); else n_pass++;
        tick;
        bus.c_response = CACHE_RESPONSE_WAIT;
        #1;
        tick;
        bus.c_response = CACHE_RESPONSE_PAGEFAULT; bus.e_cmd = CACHE_CMD_NONE;
        #1;
        n_checks++; if (bus.e_response !== CACHE_RESPONSE_PAGEFAULT) $display("FAIL pf_e_resp got %0h exp %0h", bus.e_response, CACHE_RESPONSE_PAGEFAULT); else n_pass++;
        n_checks++; if (bus.f_response !== CACHE_RESPONSE_WAIT) $display("FAIL pf_f_resp got %0h exp %0h", bus.f_response, CACHE_RESPONSE_WAIT); else n_pass++;
        n_checks++; if (bus.c_cmd !== CACHE_CMD_EXECUTE) $display("FAIL pf_release_cmd got %0h exp %0h", bus.c_cmd, CACHE_CMD_EXECUTE); else n_pass++;
        n_checks++; if (bus.c_store_data !== 32'h0) $display("FAIL pf_release_sdata got %h exp 0", bus.c_store_data); else n_pass++;
        tick;
        bus.c_response = CACHE_RESPONSE_WAIT;
        #1;
        tick;
        bus.c_response = CACHE_RESPONSE_DONE; bus.f_cmd = CACHE_CMD_NONE;
        #1;
        n_checks++; if (bus.f_response !== CACHE_RESPONSE_DONE) $display("FAIL pf_f_done got %0h exp %0h", bus.f_response, CACHE_RESPONSE_DONE); else n_pass++;
        tick;
        bus.c_response = CACHE_RESPONSE_IDLE;
    endtask

    task automatic test_reset_mid_flush;
        bus.f_cmd = CACHE_CMD_NONE; bus.e_cmd = CACHE_CMD_FLUSH_ALL; bus.e_address = 32'h0;
        bus.c_response = CACHE_RESPONSE_IDLE;
        #1;
        n_checks++; if (bus.c_cmd !== CACHE_CMD_FLUSH_ALL) $display("FAIL rm_c_cmd got %0h exp %0h", bus.c_cmd, CACHE_CMD_FLUSH_ALL); else n_pass++;
        tick;
        bus.c_response = CACHE_RESPONSE_WAIT;
        #1;
        n_checks++; if (bus.c_cmd !== CACHE_CMD_FLUSH_ALL) $display("FAIL rm_c_cmd_wait got %0h exp %0h", bus.c_cmd, CACHE_CMD_FLUSH_ALL); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.c_cmd !== CACHE_CMD_NONE) $display("FAIL rm_c_cmd_rst got %0h exp %0h", bus.c_cmd, CACHE_CMD_NONE); else n_pass++;
        n_checks++; if (dut.owner_q !== OWNER_NONE) $display("FAIL rm_owner_rst got %0d exp %0d", dut.owner_q, OWNER_NONE); else n_pass++;
        n_checks++; if (bus.f_response !== CACHE_RESPONSE_WAIT) $display("FAIL rm_f_resp_rst got %0h exp %0h", bus.f_response, CACHE_RESPONSE_WAIT); else n_pass++;
        tick;
        rst_n = 1'b1; bus.e_cmd = CACHE_CMD_NONE;
        bus.f_cmd = CACHE_CMD_EXECUTE; bus.f_address = 32'h6000; bus.c_response = CACHE_RESPONSE_IDLE;
        #1;
        n_checks++; if (bus.c_cmd !== CACHE_CMD_EXECUTE) $display("FAIL rm_post_cmd got %0h exp %0h", bus.c_cmd, CACHE_CMD_EXECUTE); else n_pass++;
        n_checks++; if (bus.c_address !== 32'h6000) $display("FAIL rm_post_addr got %h exp %h", bus.c_address, 32'h6000); else n_pass++;
        n_checks++; if (bus.e_response !== CACHE_RESPONSE_IDLE) $display("FAIL rm_post_e_resp got %0h exp %0h", bus.e_response, CACHE_RESPONSE_IDLE); else n_pass++;
        tick;
        bus.c_response = CACHE_RESPONSE_WAIT;
        #1;
        n_checks++; if (dut.owner_q !== OWNER_FETCH) $display("FAIL rm_post_owner got %0d exp %0d", dut.owner_q, OWNER_FETCH); else n_pass++;
        tick;
        bus.c_response = CACHE_RESPONSE_DONE; bus.f_cmd = CACHE_CMD_NONE;
        #1;
        tick;
        bus.c_response = CACHE_RESPONSE_IDLE;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_fetch_only();
        test_exec_priority();
        test_starvation();
        test_error_release();
        test_reset_mid_flush();
        tick;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
